led_blink_ctrl: RTL and testbench

//  Parametrised multi-channel LED/indicator driver. Successor to the fixed 50M-cycle single-LED toggle.

---
 rtl/led_pkg.sv | 46 ++++
 rtl/led_tick_gen.sv | 35 +++
 rtl/led_blink_ctrl.sv | 149 ++++++++++++++
 tb/tb_led_blink_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// ----------------------------------------------------------------------------
// led_pkg
//   Shared types and helpers for the multi-channel LED driver.
//   - led_mode_e : per-channel operating mode (2-bit encoding)
//   - led_cfg_t  : per-channel configuration {mode, period, duty}
//   - eff_period : period with 0 folded to 1
//   - led_oe_of  : pad-enable value for a given mode/state
//   Period/duty fields are stored at LED_PW_MAX bits so one struct type serves
//   every PW. The driver zero-extends its PW-bit values into them, which makes
//   the upper bits constant, so they cost nothing. PW must not exceed
//   LED_PW_MAX.
// ----------------------------------------------------------------------------
package led_pkg;

  localparam int LED_PW_MAX = 32;

  typedef enum logic [1:0] {
    LED_OFF   = 2'd0,
    LED_ON    = 2'd1,
    LED_BLINK = 2'd2,
    LED_PWM   = 2'd3
  } led_mode_e;

  typedef struct packed {
    led_mode_e               mode;
    logic [LED_PW_MAX-1:0]   period;
    logic [LED_PW_MAX-1:0]   duty;
  } led_cfg_t;

  // A period of 0 behaves exactly like a period of 1.
  function automatic logic [LED_PW_MAX-1:0] eff_period(input logic [LED_PW_MAX-1:0] p);
    return (p == '0) ? LED_PW_MAX'(1) : p;
  endfunction

  function automatic logic led_oe_of(input led_mode_e mode, input logic blink,
                                     input logic [LED_PW_MAX-1:0] phase,
                                     input logic [LED_PW_MAX-1:0] duty);
    case (mode)
      LED_ON:    return 1'b1;
      LED_BLINK: return blink;
      LED_PWM:   return (phase < duty);
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// ----------------------------------------------------------------------------
// led_tick_gen
//   Free-running prescaler. Counts 0..DIV-1 and emits a registered one-cycle
//   tick in the cycle after the count reaches DIV-1.
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous active-high reset
//   tick  out  one-cycle pulse every DIV clocks (registered)
// ----------------------------------------------------------------------------
module led_tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;
  logic          at_last;

  assign at_last = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= at_last;
      cnt  <= at_last ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/led_blink_ctrl.sv
// ----------------------------------------------------------------------------
// led_blink_ctrl
//   Multi-channel LED / indicator driver for open-drain pads. A shared
//   prescaler tick advances a per-channel phase counter; each channel is OFF,
//   ON, BLINK (toggle on every phase wrap) or PWM (on while phase < duty).
//   Config is written through a one-entry port, either applied at once
//   (SYNC_UPDATE=0) or staged in a shadow register and applied at the target
//   channel's next phase wrap (SYNC_UPDATE=1).
// Ports:
//   sys_clk     in   system clock
//   reset       in   asynchronous active-high reset
//   cfg_we      in   config write strobe
//   cfg_ch      in   target channel (writes to cfg_ch >= CH are dropped)
//   cfg_mode    in   0 OFF, 1 ON, 2 BLINK, 3 PWM
//   cfg_period  in   period in ticks (0 behaves as 1)
//   cfg_duty    in   PWM on-time in ticks
//   cfg_ready   out  write port accepts cfg_we
//   led_oe      out  per-channel pad enable, 1 = pull pad low (lit); registered
//   tick        out  prescaler pulse, one cycle every CLK_HZ/TICK_HZ clocks
// ----------------------------------------------------------------------------
module led_blink_ctrl
  import led_pkg::*;
#(
  parameter int CLK_HZ      = 50000000,
  parameter int TICK_HZ     = 1000,
  parameter int CH          = 4,
  parameter int PW          = 16,
  parameter int SYNC_UPDATE = 0
) (
  input  logic                  sys_clk,
  input  logic                  reset,
  input  logic                  cfg_we,
  input  logic [$clog2(CH)-1:0] cfg_ch,
  input  logic [1:0]            cfg_mode,
  input  logic [PW-1:0]         cfg_period,
  input  logic [PW-1:0]         cfg_duty,
  output logic                  cfg_ready,
  output logic [CH-1:0]         led_oe,
  output logic                  tick
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int CHW = $clog2(CH);

  logic tick_i;

  led_tick_gen #(.DIV(DIV)) u_tick (
    .clk  (sys_clk),
    .rst  (reset),
    .tick (tick_i)
  );

  assign tick = tick_i;

  // Write-port decode and shadow staging.
  logic          cfg_ch_ok;
  led_cfg_t      wr_cfg;
  logic          pending;
  logic [CHW-1:0] shadow_ch;
  led_cfg_t      shadow_cfg;
  logic [CH-1:0] copy_hit;

  assign cfg_ch_ok = (int'(cfg_ch) < CH);
  assign wr_cfg    = '{mode:   led_mode_e'(cfg_mode),
                       period: LED_PW_MAX'(cfg_period),
                       duty:   LED_PW_MAX'(cfg_duty)};

  // pending is a flop, so cfg_ready is glitch-free and drops the cycle after
  // an accepted write and rises the cycle after the shadow is copied.
  assign cfg_ready = ~pending;

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      pending    <= 1'b0;
      shadow_ch  <= '0;
      shadow_cfg <= '0;
    end else if (SYNC_UPDATE != 0) begin
      if (!pending) begin
        if (cfg_we && cfg_ch_ok) begin
          pending    <= 1'b1;
          shadow_ch  <= cfg_ch;
          shadow_cfg <= wr_cfg;
        end
      end else if (|copy_hit) begin
        pending <= 1'b0;
      end
    end
  end

  // Per-channel phase / blink / output logic.
  for (genvar i = 0; i < CH; i++) begin : g_ch
    led_cfg_t               cfg_q, cfg_n, load_cfg;
    logic [PW-1:0]          phase_q, phase_n;
    logic                   blink_q, blink_n;
    logic                   oe_q;
    logic [LED_PW_MAX-1:0]  last_phase;
    logic                   at_wrap, sync_load, direct_load, do_load;

    assign last_phase = eff_period(cfg_q.period) - LED_PW_MAX'(1);
    assign at_wrap    = (LED_PW_MAX'(phase_q) == last_phase);

    // A staged write lands on a static channel (OFF/ON) right away, on an
    // animated one only at a wrap so the visible pattern never gets cut.
    assign sync_load   = pending && (shadow_ch == CHW'(i)) &&
                         ((cfg_q.mode == LED_OFF) || (cfg_q.mode == LED_ON) ||
                          (tick_i && at_wrap));
    assign direct_load = cfg_we && cfg_ch_ok && (cfg_ch == CHW'(i));
    assign do_load     = (SYNC_UPDATE != 0) ? sync_load : direct_load;
    assign load_cfg    = (SYNC_UPDATE != 0) ? shadow_cfg : wr_cfg;
    assign copy_hit[i] = do_load;

    // A load takes priority over a coincident tick: the new config always
    // starts from phase 0 with the blink state cleared.
    always_comb begin
      cfg_n   = cfg_q;
      phase_n = phase_q;
      blink_n = blink_q;
      if (do_load) begin
        cfg_n   = load_cfg;
        phase_n = '0;
        blink_n = 1'b0;
      end else if (tick_i) begin
        if (at_wrap) begin
          phase_n = '0;
          if (cfg_q.mode == LED_BLINK) blink_n = ~blink_q;
        end else begin
          phase_n = phase_q + PW'(1);
        end
      end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
        cfg_q   <= '0;
        phase_q <= '0;
        blink_q <= 1'b0;
        oe_q    <= 1'b0;
      end else begin
        cfg_q   <= cfg_n;
        phase_q <= phase_n;
        blink_q <= blink_n;
        oe_q    <= led_oe_of(cfg_n.mode, blink_n, LED_PW_MAX'(phase_n), cfg_n.duty);
      end
    end

    assign led_oe[i] = oe_q;
  end

endmodule

// File: tb/tb_led_blink_ctrl.sv
module tb_led_blink_ctrl;
  localparam int CLK_HZ  = 1000;
  localparam int TICK_HZ = 100;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int PW      = 8;
  localparam int CHA     = 4;  // immediate-update instance
  localparam int CHB     = 3;  // shadow-update instance; channel 3 is out of range

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic we_a = 1'b0, we_b = 1'b0;
  logic [1:0] ch_a = '0, ch_b = '0, mode = '0;
  logic [PW-1:0] period = '0, duty = '0;
  logic ready_a, ready_b, tick_a, tick_b;
  logic [CHA-1:0] oe_a;
  logic [CHB-1:0] oe_b;

  always #5 clk = ~clk;

  led_blink_ctrl #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .CH(CHA), .PW(PW), .SYNC_UPDATE(0)) dut_a (
    .sys_clk(clk), .reset(reset), .cfg_we(we_a), .cfg_ch(ch_a), .cfg_mode(mode),
    .cfg_period(period), .cfg_duty(duty), .cfg_ready(ready_a), .led_oe(oe_a), .tick(tick_a));

  led_blink_ctrl #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .CH(CHB), .PW(PW), .SYNC_UPDATE(1)) dut_b (
    .sys_clk(clk), .reset(reset), .cfg_we(we_b), .cfg_ch(ch_b), .cfg_mode(mode),
    .cfg_period(period), .cfg_duty(duty), .cfg_ready(ready_b), .led_oe(oe_b), .tick(tick_b));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: index 0 = dut_a, 1 = dut_b. Plain integer bookkeeping.
  int m_n;  // clock edges since reset release
  int m_mode[2][4], m_per[2][4], m_duty[2][4], m_phase[2][4], m_blink[2][4];
  bit m_pend;
  int sh_ch, sh_mode, sh_per, sh_duty;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_n = 0;
    m_pend = 1'b0;
    sh_ch = 0; sh_mode = 0; sh_per = 0; sh_duty = 0;
    for (int m = 0; m < 2; m++)
      for (int c = 0; c < 4; c++) begin
        m_mode[m][c] = 0; m_per[m][c] = 0; m_duty[m][c] = 0;
        m_phase[m][c] = 0; m_blink[m][c] = 0;
      end
  endfunction

  function automatic bit exp_tick();
    return (m_n > 0) && (m_n % DIV == 0);
  endfunction

  function automatic bit exp_oe(input int m, input int c);
    case (m_mode[m][c])
      1:       return 1'b1;
      2:       return m_blink[m][c] != 0;
      3:       return m_phase[m][c] < m_duty[m][c];
      default: return 1'b0;
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs presented to it.
  function automatic void model_step();
    bit t, copy, ld;
    int nch, eff;
    t = exp_tick();
    copy = 1'b0;
    if (m_pend) begin
      eff  = (m_per[1][sh_ch] == 0) ? 1 : m_per[1][sh_ch];
      copy = (m_mode[1][sh_ch] < 2) || (t && ((m_phase[1][sh_ch] + 1) % eff == 0));
    end
    for (int m = 0; m < 2; m++) begin
      nch = (m == 0) ? CHA : CHB;
      for (int c = 0; c < nch; c++) begin
        if (m == 0) ld = we_a && (int'(ch_a) < CHA) && (int'(ch_a) == c);
        else        ld = copy && (sh_ch == c);
        if (ld) begin
          if (m == 0) begin
            m_mode[0][c] = int'(mode); m_per[0][c] = int'(period); m_duty[0][c] = int'(duty);
          end else begin
            m_mode[1][c] = sh_mode; m_per[1][c] = sh_per; m_duty[1][c] = sh_duty;
          end
          m_phase[m][c] = 0;
          m_blink[m][c] = 0;
        end else if (t) begin
          eff = (m_per[m][c] == 0) ? 1 : m_per[m][c];
          m_phase[m][c] = (m_phase[m][c] + 1) % eff;
          if (m_phase[m][c] == 0 && m_mode[m][c] == 2) m_blink[m][c] = 1 - m_blink[m][c];
        end
      end
    end
    if (copy) m_pend = 1'b0;
    else if (!m_pend && we_b && (int'(ch_b) < CHB)) begin
      m_pend = 1'b1;
      sh_ch = int'(ch_b); sh_mode = int'(mode); sh_per = int'(period); sh_duty = int'(duty);
    end
    m_n++;
  endfunction

  task automatic check_all();
    logic [31:0] ea, eb;
    ea = '0; eb = '0;
    for (int c = 0; c < CHA; c++) ea[c[4:0]] = exp_oe(0, c);
    for (int c = 0; c < CHB; c++) eb[c[4:0]] = exp_oe(1, c);
    check("tick_a", 32'(tick_a), 32'(exp_tick()));
    check("tick_b", 32'(tick_b), 32'(exp_tick()));
    check("ready_a", 32'(ready_a), 32'd1);
    check("ready_b", 32'(ready_b), 32'(!m_pend));
    check("oe_a", 32'(oe_a), ea);
    check("oe_b", 32'(oe_b), eb);
  endtask

  // One clock: edge, model update, sample on the falling edge.
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  // Called on a falling edge: reset asserted between edges, outputs must clear at once.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    check_all();
    reset = 1'b0;
  endtask

  task automatic write_a(input int c, input int md, input int p, input int d);
    ch_a = c[1:0]; mode = md[1:0]; period = p[PW-1:0]; duty = d[PW-1:0];
    we_a = 1'b1;
    cyc();
    we_a = 1'b0;
  endtask

  task automatic write_b(input int c, input int md, input int p, input int d);
    ch_b = c[1:0]; mode = md[1:0]; period = p[PW-1:0]; duty = d[PW-1:0];
    we_b = 1'b1;
    cyc();
    we_b = 1'b0;
  endtask

  function automatic logic cur(input int sel, input int b);
    logic [31:0] v;
    v = (sel != 0) ? 32'(oe_b) : 32'(oe_a);
    return v[b[4:0]];
  endfunction

  // Clocks between the first two changes of one LED output (-1 on timeout).
  task automatic measure_toggle(input int sel, input int b, output int iv);
    logic prev;
    int t0;
    iv = -1; t0 = -1;
    prev = cur(sel, b);
    for (int k = 1; k <= 300 && iv < 0; k++) begin
      cyc();
      if (cur(sel, b) !== prev) begin
        prev = cur(sel, b);
        if (t0 < 0) t0 = k;
        else iv = k - t0;
      end
    end
  endtask

  task automatic count_high(input int sel, input int b, input int n, output int cnt);
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      cyc();
      if (cur(sel, b) === 1'b1) cnt++;
    end
  endtask

  // Length of the current run of 1s on dut_a's output b, starting at this sample.
  task automatic high_run(input int b, output int len);
    len = (cur(0, b) === 1'b1) ? 1 : 0;
    while (len > 0 && len < 100 && cur(0, b) === 1'b1) begin
      cyc();
      if (cur(0, b) === 1'b1) len++;
    end
  endtask

  task automatic wait_tick();
    for (int k = 0; k < 2 * DIV; k++)
      if (tick_a !== 1'b1) cyc();
  endtask

  initial begin
    int lat, iv, cnt, seen, r;

    @(negedge clk);
    do_reset();

    // Reset release: first tick DIV clocks later.
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      if (lat < 0 && tick_a === 1'b1) lat = k;
    end
    check("first_tick_latency", 32'(lat), 32'd10);

    // BLINK period 5 on ch0: toggles every 50 clocks.
    write_a(0, 2, 5, 0);
    measure_toggle(0, 0, iv);
    check("blink_p5_interval", 32'(iv), 32'd50);

    // PWM period 4 on ch2.
    write_a(2, 3, 4, 1);
    count_high(0, 2, 120, cnt);
    check("pwm_duty1_high", 32'(cnt), 32'd30);
    write_a(2, 3, 4, 4);
    count_high(0, 2, 40, cnt);
    check("pwm_duty_full_high", 32'(cnt), 32'd40);
    write_a(2, 3, 4, 0);
    count_high(0, 2, 40, cnt);
    check("pwm_duty0_high", 32'(cnt), 32'd0);

    // Period 0 blinks on every tick.
    write_a(1, 2, 0, 0);
    measure_toggle(0, 1, iv);
    check("blink_p0_interval", 32'(iv), 32'd10);

    // Write landing together with a tick restarts at phase 0: PWM 2/4 stays lit 2 ticks.
    wait_tick();
    check("tick_before_write", 32'(tick_a), 32'd1);
    write_a(3, 3, 4, 2);
    high_run(3, cnt);
    check("write_on_tick_run", 32'(cnt), 32'd20);

    // ON / OFF take effect on the write edge.
    write_a(3, 1, 0, 0);
    check("on_immediate", 32'(oe_a[3]), 32'd1);
    write_a(3, 0, 0, 0);
    check("off_immediate", 32'(oe_a[3]), 32'd0);

    // Shadow instance: out-of-range channel is dropped.
    write_b(3, 1, 1, 1);
    check("bad_ch_ready", 32'(ready_b), 32'd1);
    check("bad_ch_oe", 32'(oe_b), 32'd0);
    repeat (3) cyc();

    // Shadow instance: ch1 BLINK 5, then retune to 2 mid-phase.
    write_b(1, 2, 5, 0);
    repeat (23) cyc();
    write_b(1, 2, 2, 0);
    check("sync_busy", 32'(ready_b), 32'd0);
    write_b(1, 3, 1, 1);  // arrives while busy
    seen = 0;
    for (int k = 0; k < 200 && seen == 0; k++) begin
      if (ready_b === 1'b1) seen = 1;
      else cyc();
    end
    check("sync_ready_return", 32'(seen), 32'd1);
    measure_toggle(1, 1, iv);
    check("sync_new_interval", 32'(iv), 32'd20);

    // Randomised traffic against the model.
    for (int it = 0; it < 250; it++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2)
        do_reset();
      else if (r < 40)
        write_a(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 6)), int'($urandom_range(0, 7)));
      else if (r < 70)
        write_b(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 6)), int'($urandom_range(0, 7)));
      else
        repeat (int'($urandom_range(1, 25))) cyc();
    end

    // Reset in the middle of activity.
    write_a(0, 1, 0, 0);
    write_b(2, 2, 3, 0);
    do_reset();
    check("rst_oe_a", 32'(oe_a), 32'd0);
    check("rst_ready_b", 32'(ready_b), 32'd1);
    repeat (20) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
